// File: rtl/alu_pkg.sv
// Shared definitions for the 2-bit ALU and its hardware self-test.
package alu_pkg;

    // ALU operation select encodings
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_MUL   = 2'b10;
    localparam logic [1:0] OP_LOGIC = 2'b11;

    // Exhaustive sweep size: {A,B,sel} = 6 bits
    localparam int NUM_VECTORS = 64;

    // Self-test sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 2-bit ALU; 4-bit result for every op.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] sel,
    output logic [3:0] y
);

    // Widen operands to 4 bits first so add/sub/mul wrap mod 16 naturally
    always_comb begin
        y = 4'h0;
        case (sel)
            OP_ADD:   y = {2'b00, a} + {2'b00, b};
            OP_SUB:   y = {2'b00, a} - {2'b00, b};
            OP_MUL:   y = {2'b00, a} * {2'b00, b};
            OP_LOGIC: y = {a & b, a | b};
            default:  y = 4'h0;
        endcase
    end

endmodule

// File: rtl/alu_self_test.sv
// Exhaustive stimulus generator and response checker for the 2-bit ALU.
// Walks v = {A,B,sel} = 0..63, holds each vector SETTLE cycles, then
// compares alu_y against the reference model in a dedicated CHECK cycle.
module alu_self_test
    import alu_pkg::*;
#(
    parameter int SETTLE = 2  // legal range 1..15 (settle counter is 4 bits)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [3:0] alu_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_count,
    output logic       first_fail_valid,
    output logic [5:0] first_fail_vec
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [5:0] LAST_VEC    = 6'(NUM_VECTORS - 1);

    state_t     state;
    logic [5:0] v;
    logic [3:0] cnt;
    logic [3:0] exp_y;
    logic       mismatch;

    // ALU operands come straight from the vector register, so they only
    // move on the edge that enters APPLY and are stable through CHECK.
    assign alu_a   = v[5:4];
    assign alu_b   = v[3:2];
    assign alu_sel = v[1:0];

    alu_ref_model u_ref (
        .a   (v[5:4]),
        .b   (v[3:2]),
        .sel (v[1:0]),
        .y   (exp_y)
    );

    assign mismatch = (alu_y != exp_y);

    // Sequencer FSM with counters and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            v                <= 6'd0;
            cnt              <= 4'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 7'd0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= 6'd0;
        end else begin
            case (state)
                // DONE restarts exactly like IDLE; start is ignored elsewhere
                IDLE, DONE: begin
                    if (start) begin
                        state            <= APPLY;
                        v                <= 6'd0;
                        cnt              <= 4'd0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= 7'd0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= 6'd0;
                    end
                end
                APPLY: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == SETTLE_LAST)
                        state <= CHECK;
                end
                CHECK: begin
                    // 64 vectors at most, so 7 bits never wrap
                    if (mismatch) begin
                        err_count <= err_count + 7'd1;
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= v;
                        end
                    end
                    if (v == LAST_VEC) begin
                        // Final verdict must include this last comparison
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 7'd0) && !mismatch;
                    end else begin
                        v     <= v + 6'd1;
                        cnt   <= 4'd0;
                        state <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_self_test.sv
// Directed bench for alu_self_test: behavioural ALU with injectable faults,
// a table of full sweeps plus hand-written reset/restart/SETTLE=1 cases.
module tb_alu_self_test;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start2 = 1'b0, start1 = 1'b0;
    logic [1:0] a2, b2, s2, a1, b1, s1;
    logic [3:0] y2, y1;
    logic       busy2, done2, pass2, ffv2, busy1, done1, pass1, ffv1;
    logic [6:0] err2, err1;
    logic [5:0] ffvec2, ffvec1;
    int         fault2 = 0;  // 0 ok, 1 y=0, 2 v=45 returns E, 3 y=ref+1

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_self_test #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .alu_a(a2), .alu_b(b2), .alu_sel(s2), .alu_y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
    );

    alu_self_test #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .alu_a(a1), .alu_b(b1), .alu_sel(s1), .alu_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
    );

    // Behavioural 2-bit ALU
    function automatic logic [3:0] alu_f(logic [1:0] a, logic [1:0] b, logic [1:0] s);
        logic [3:0] ea, eb;
        ea = 4'(a);
        eb = 4'(b);
        case (s)
            2'b00:   return ea + eb;
            2'b01:   return ea - eb;
            2'b10:   return ea * eb;
            default: return {a & b, a | b};
        endcase
    endfunction

    always_comb begin
        y2 = alu_f(a2, b2, s2);
        case (fault2)
            1: y2 = 4'h0;
            2: if ({a2, b2, s2} == 6'b101101) y2 = 4'hE;
            3: y2 = alu_f(a2, b2, s2) + 4'h1;
            default: ;
        endcase
    end

    assign y1 = alu_f(a1, b1, s1);

    // Vector-order monitor: ALU inputs must step 0,1,2,...,63 during a sweep
    bit         mon = 1'b0;
    logic [5:0] prev;
    int         changes, bad;
    always @(negedge clk) begin
        if (!mon) begin
            prev    <= 6'd0;
            changes <= 0;
            bad     <= 0;
        end else if (busy2 && {a2, b2, s2} != prev) begin
            changes <= changes + 1;
            if ({a2, b2, s2} != prev + 6'd1) bad <= bad + 1;
            prev <= {a2, b2, s2};
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start for one cycle; returns #1 after the sampling edge
    task automatic kick(input int which);
        @(negedge clk);
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Count edges (sampling edge = 1) until done; optional start re-pulse
    task automatic wait_done(input int which, input int repulse, output int lat);
        lat = 1;
        while (((which == 1) ? done1 : done2) !== 1'b1 && lat < 2000) begin
            start2 = (which == 2 && lat == repulse);
            @(posedge clk);
            #1;
            start2 = 1'b0;
            lat++;
        end
    endtask

    typedef struct {
        int         fault;
        int         exp_err;
        int         exp_pass;
        int         exp_ffv;
        logic [5:0] exp_ffvec;
    } row_t;

    row_t rows[4];
    int   lat;

    initial begin
        rows[0] = '{0,  0, 1, 0, 6'b000000};
        rows[1] = '{1, 51, 0, 1, 6'b000100};
        rows[2] = '{2,  1, 0, 1, 6'b101101};
        rows[3] = '{3, 64, 0, 1, 6'b000000};

        // Reset state
        #12;
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_pass", pass2, 0);
        chk("rst_err", err2, 0);
        chk("rst_vec", {a2, b2, s2}, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            fault2 = rows[i].fault;
            mon = (i == 0);
            kick(2);
            chk($sformatf("r%0d_busy", i), busy2, 1);
            wait_done(2, -1, lat);
            chk($sformatf("r%0d_lat", i), lat, 193);
            chk($sformatf("r%0d_err", i), err2, rows[i].exp_err);
            chk($sformatf("r%0d_pass", i), pass2, rows[i].exp_pass);
            chk($sformatf("r%0d_ffv", i), ffv2, rows[i].exp_ffv);
            if (rows[i].exp_ffv != 0) chk($sformatf("r%0d_ffvec", i), ffvec2, rows[i].exp_ffvec);
            chk($sformatf("r%0d_busy_end", i), busy2, 0);
            chk($sformatf("r%0d_hold_vec", i), {a2, b2, s2}, 63);
            if (i == 0) begin
                chk("order_changes", changes, 63);
                chk("order_bad", bad, 0);
            end
        end
        mon = 1'b0;

        // Start in DONE (after err=64 sweep): everything clears next cycle
        fault2 = 0;
        kick(2);
        chk("restart_done", done2, 0);
        chk("restart_busy", busy2, 1);
        chk("restart_err", err2, 0);
        chk("restart_ffv", ffv2, 0);
        chk("restart_vec", {a2, b2, s2}, 0);
        wait_done(2, -1, lat);
        chk("restart_lat", lat, 193);
        chk("restart_pass", pass2, 1);

        // start re-pulsed while busy is ignored
        kick(2);
        wait_done(2, 40, lat);
        chk("repulse_lat", lat, 193);
        chk("repulse_pass", pass2, 1);

        // Reset mid-sweep drops partial results
        fault2 = 1;
        kick(2);
        repeat (99) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy2, 0);
        chk("midrst_done", done2, 0);
        chk("midrst_pass", pass2, 0);
        chk("midrst_err", err2, 0);
        chk("midrst_ffv", ffv2, 0);
        chk("midrst_ffvec", ffvec2, 0);
        chk("midrst_vec", {a2, b2, s2}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fault2 = 0;
        kick(2);
        wait_done(2, -1, lat);
        chk("postrst_lat", lat, 193);
        chk("postrst_err", err2, 0);
        chk("postrst_pass", pass2, 1);
        chk("postrst_ffv", ffv2, 0);

        // SETTLE=1 instance
        kick(1);
        wait_done(1, -1, lat);
        chk("s1_lat", lat, 129);
        chk("s1_pass", pass1, 1);
        chk("s1_err", err1, 0);
        chk("s1_ffv", ffv1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
